// File: rtl/dual_prior_enc_pkg.sv
// Shared constants and helpers for the dual priority encoder.
// Holds the default request width, index width computation and the zero index.
package dual_prior_enc_pkg;

   localparam int WIDTH_DEF = 12;
   localparam int ZERO_IDX  = 0;

   // At least one index bit even for the narrowest legal request vector.
   function automatic int idx_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/dual_prior_enc_prio_enc.sv
// MSB-first priority encoder: index of the highest set request bit plus valid.
// Latency: combinational. Backpressure: none, evaluates every cycle.
module prio_enc
   import dual_prior_enc_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int IDX_W = idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0] req,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

   // Ascending scan: the last set bit seen is the highest, so it wins.
   always_comb begin
      idx = IDX_W'(ZERO_IDX);
      vld = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (req[i]) begin
            idx = IDX_W'(i);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dual_prior_enc.sv
// Dual priority encoder: indices of the two highest set bits of in, MSB first.
// Latency: 0 cycles, or 1 cycle with DUAL_PRIOR_ENC_REG_OUT_EN defined. Backpressure: none.
module dual_prior_enc
   import dual_prior_enc_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int IDX_W = idx_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   output logic [IDX_W-1:0] first,
   output logic [IDX_W-1:0] second,
   output logic             first_vld,
   output logic             second_vld
);

   logic [IDX_W-1:0] f_idx;
   logic [IDX_W-1:0] s_idx;
   logic             f_v;
   logic             s_v;
   logic [WIDTH-1:0] first_oh;
   logic [WIDTH-1:0] masked;

   prio_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc_first (
      .req (in),
      .idx (f_idx),
      .vld (f_v)
   );

   // Knock out the winning bit via a decode of its index; the rest competes for second.
   assign first_oh = f_v ? (WIDTH'(1) << f_idx) : '0;
   assign masked   = in & ~first_oh;

   prio_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc_second (
      .req (masked),
      .idx (s_idx),
      .vld (s_v)
   );

`ifdef DUAL_PRIOR_ENC_REG_OUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first      <= IDX_W'(ZERO_IDX);
         second     <= IDX_W'(ZERO_IDX);
         first_vld  <= 1'b0;
         second_vld <= 1'b0;
      end else begin
         first      <= f_idx;
         second     <= s_idx;
         first_vld  <= f_v;
         second_vld <= s_v;
      end
   end
`else
   // Clock and reset are kept on the port list so both builds share one footprint.
   logic unused_clk_rst;
   assign unused_clk_rst = clk | rst;

   assign first      = f_idx;
   assign second     = s_idx;
   assign first_vld  = f_v;
   assign second_vld = s_v;
`endif

endmodule

// File: tb/tb_dual_prior_enc.sv
// Self-checking bench for dual_prior_enc; covers both the combinational and registered builds.
module tb_dual_prior_enc;

   localparam int W  = 12;
   localparam int IW = 4;
`ifdef DUAL_PRIOR_ENC_REG_OUT_EN
   localparam bit REG_OUT = 1'b1;
`else
   localparam bit REG_OUT = 1'b0;
`endif

   typedef struct packed {
      logic [IW-1:0] f;
      logic [IW-1:0] s;
      logic          fv;
      logic          sv;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  in_v = '0;
   logic [IW-1:0] first;
   logic [IW-1:0] second;
   logic          first_vld;
   logic          second_vld;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   dual_prior_enc #(.WIDTH(W), .IDX_W(IW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in         (in_v),
      .first      (first),
      .second     (second),
      .first_vld  (first_vld),
      .second_vld (second_vld)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: walk down from the MSB and record the first two hits.
   function automatic exp_t ref_enc(input logic [W-1:0] v);
      exp_t r;
      int   hits;
      r    = '0;
      hits = 0;
      for (int i = W - 1; i >= 0; i--) begin
         if (v[i]) begin
            if (hits == 0) begin
               r.f  = IW'(i);
               r.fv = 1'b1;
            end else if (hits == 1) begin
               r.s  = IW'(i);
               r.sv = 1'b1;
            end
            hits++;
         end
      end
      return r;
   endfunction

   // Drive one vector, queue its expectation, then pop and compare once the DUT has produced it.
   task automatic apply(input logic [W-1:0] v, input exp_t e, input bit detailed, input string tag);
      exp_t ex;
      exp_t got;
      @(negedge clk);
      in_v = v;
      sb.push_back(e);
      if (REG_OUT) begin
         @(posedge clk);
         #1;
      end else begin
         #1;
      end
      if (sb.size() == 0) begin
         check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         ex  = sb.pop_front();
         got = '{f: first, s: second, fv: first_vld, sv: second_vld};
         if (detailed) begin
            check_val({tag, "_first"},      32'(got.f),  32'(ex.f));
            check_val({tag, "_second"},     32'(got.s),  32'(ex.s));
            check_val({tag, "_first_vld"},  32'(got.fv), 32'(ex.fv));
            check_val({tag, "_second_vld"}, 32'(got.sv), 32'(ex.sv));
         end else begin
            check_val(tag, 32'(got), 32'(ex));
         end
      end
   endtask

   function automatic exp_t mk(input int f, input int s, input bit fv, input bit sv);
      exp_t r;
      r.f  = IW'(f);
      r.s  = IW'(s);
      r.fv = fv;
      r.sv = sv;
      return r;
   endfunction

   initial begin
      // Reset / idle state with no requests.
      #12;
      check_val("rst_first",      32'(first),      32'd0);
      check_val("rst_second",     32'(second),     32'd0);
      check_val("rst_first_vld",  32'(first_vld),  32'd0);
      check_val("rst_second_vld", 32'(second_vld), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      apply(12'b001001000011, mk(9, 6, 1'b1, 1'b1),  1'b1, "vec_9_6");
      apply(12'b111111000001, mk(11, 10, 1'b1, 1'b1), 1'b1, "vec_11_10");
      apply(12'b101100000110, mk(11, 9, 1'b1, 1'b1),  1'b1, "vec_11_9");
      apply(12'b000000000000, mk(0, 0, 1'b0, 1'b0),   1'b1, "vec_zero");
      apply(12'b000000000001, mk(0, 0, 1'b1, 1'b0),   1'b1, "vec_bit0");
      apply(12'b100000000000, mk(11, 0, 1'b1, 1'b0),  1'b1, "vec_bit11");
      apply(12'b100000000001, mk(11, 0, 1'b1, 1'b1),  1'b1, "vec_ends");
      apply(12'b000000000011, mk(1, 0, 1'b1, 1'b1),   1'b1, "vec_low2");
      apply(12'b000010000000, mk(7, 0, 1'b1, 1'b0),   1'b1, "vec_single7");

      // Asynchronous reset with all requests set.
      @(negedge clk);
      in_v = 12'hFFF;
      @(posedge clk);
      #1;
      check_val("pre_rst_first",  32'(first),  32'd11);
      check_val("pre_rst_second", 32'(second), 32'd10);
      #2;
      rst = 1'b1;
      #1;
      if (REG_OUT) begin
         check_val("arst_first",      32'(first),      32'd0);
         check_val("arst_second",     32'(second),     32'd0);
         check_val("arst_first_vld",  32'(first_vld),  32'd0);
         check_val("arst_second_vld", 32'(second_vld), 32'd0);
         @(posedge clk);
         #1;
         check_val("arst_hold_first", 32'(first), 32'd0);
         check_val("arst_hold_vld",   32'(first_vld), 32'd0);
      end else begin
         check_val("comb_rst_first",  32'(first),  32'd11);
         check_val("comb_rst_second", 32'(second), 32'd10);
         check_val("comb_rst_vld",    32'({first_vld, second_vld}), 32'd3);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_val("post_rst_first",  32'(first),  32'd11);
      check_val("post_rst_second", 32'(second), 32'd10);
      check_val("post_rst_vld",    32'({first_vld, second_vld}), 32'd3);

      // Full sweep against the reference model.
      for (int v = 0; v < (1 << W); v++) begin
         apply(W'(v), ref_enc(W'(v)), 1'b0, $sformatf("sweep_%03h", v));
      end

      check_val("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
